fft_frame_sequencer: RTL and testbench

Frame sequencer between the sample source and the FFT core's Avalon-ST sink port. Accepts a valid/ready complex sample stream, cuts it into frames of a programmable power-of-two length, and drives the core's sink handshake (valid/sop/eop/error) with backpressure from `sink_ready`. Latches transform length and direction once per frame, counts completed frames, and parks in an error state when the core reports a stream error.

---
 rtl/fft_ctrl_pkg.sv | 31 +++
 rtl/fft_sink_outreg.sv | 44 ++++
 rtl/fft_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Holds FSM encoding, length limits and the length check.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int MIN_LOG2_DEF = 6;
    localparam int MAX_LOG2_DEF = 10;

    localparam logic [1:0] SINK_ERR_NONE = 2'b00;

    // Power of two within [2^min_log2, 2^max_log2]; zero fails the range test.
    function automatic logic pts_ok(
        input logic [31:0] pts,
        input int          min_log2,
        input int          max_log2
    );
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'd1 << min_log2;
        hi = 32'd1 << max_log2;
        return ((pts & (pts - 32'd1)) == 32'd0)
            && (pts >= lo) && (pts <= hi);
    endfunction

endpackage

// File: rtl/fft_sink_outreg.sv
// One-entry output register feeding the FFT core sink port.
// Loads on accept, holds while stalled, drains on ready.
module fft_sink_outreg #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          load,
    input  logic [DW-1:0] d_real,
    input  logic [DW-1:0] d_imag,
    input  logic          d_sop,
    input  logic          d_eop,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] q_real,
    output logic [DW-1:0] q_imag,
    output logic          q_sop,
    output logic          q_eop
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid  <= 1'b0;
            q_real <= '0;
            q_imag <= '0;
            q_sop  <= 1'b0;
            q_eop  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            q_sop <= 1'b0;
            q_eop <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q_real <= d_real;
            q_imag <= d_imag;
            q_sop  <= d_sop;
            q_eop  <= d_eop;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Cuts a sample stream into power-of-two frames for the FFT core.
// Latches length/direction per frame and parks on core errors.
module fft_frame_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int DW       = 12,
    parameter int MAX_LOG2 = MAX_LOG2_DEF,
    parameter int MIN_LOG2 = MIN_LOG2_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [MAX_LOG2:0]   cfg_pts,
    input  logic                cfg_inverse,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_real,
    input  logic [DW-1:0]       in_imag,
    output logic                sink_valid,
    input  logic                sink_ready,
    output logic                sink_sop,
    output logic                sink_eop,
    output logic [1:0]          sink_error,
    output logic [DW-1:0]       sink_real,
    output logic [DW-1:0]       sink_imag,
    output logic [MAX_LOG2:0]   fft_pts,
    output logic                inverse,
    input  logic [1:0]          source_error,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                err,
    output logic                cfg_err
);

    localparam int PW = MAX_LOG2 + 1;

    state_t        state, state_d;
    logic [PW-1:0] beat_cnt;
    logic          accept;
    logic          last_beat;
    logic          src_err;
    logic          cfg_ok;
    logic          latch_cfg;
    logic          set_cfg_err;
    logic          clr_err;

    assign src_err   = (source_error != 2'b00) && (state != ST_ERROR);
    assign cfg_ok    = pts_ok(32'(cfg_pts), MIN_LOG2, MAX_LOG2);
    assign in_ready  = (state == ST_RUN) && (!sink_valid || sink_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == fft_pts - PW'(1));

    assign frame_done = sink_valid && sink_ready && sink_eop;
    assign sink_error = SINK_ERR_NONE;
    assign err        = (state == ST_ERROR);

    always_comb begin
        state_d     = state;
        latch_cfg   = 1'b0;
        set_cfg_err = 1'b0;
        clr_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Previous eop must have left the output register first.
                if (!sink_valid) begin
                    if (cfg_ok) begin
                        latch_cfg = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        set_cfg_err = 1'b1;
                        state_d     = ST_ERROR;
                    end
                end
            end
            ST_RUN: begin
                if (accept && last_beat)
                    state_d = enable ? ST_LOAD : ST_IDLE;
            end
            ST_ERROR: begin
                if (clear) begin
                    clr_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (src_err) begin
            state_d     = ST_ERROR;
            latch_cfg   = 1'b0;
            set_cfg_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            fft_pts     <= PW'(1) << MAX_LOG2;
            inverse     <= 1'b0;
            cfg_err     <= 1'b0;
            beat_cnt    <= '0;
            frame_count <= '0;
        end else begin
            state <= state_d;
            if (latch_cfg) begin
                fft_pts  <= cfg_pts;
                inverse  <= cfg_inverse;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + PW'(1);
            end
            if (set_cfg_err)
                cfg_err <= 1'b1;
            else if (clr_err)
                cfg_err <= 1'b0;
            if (frame_done)
                frame_count <= frame_count + 16'd1;
        end
    end

    fft_sink_outreg #(
        .DW (DW)
    ) u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (src_err),
        .load    (accept),
        .d_real  (in_real),
        .d_imag  (in_imag),
        .d_sop   (beat_cnt == '0),
        .d_eop   (last_beat),
        .ready   (sink_ready),
        .valid   (sink_valid),
        .q_real  (sink_real),
        .q_imag  (sink_imag),
        .q_sop   (sink_sop),
        .q_eop   (sink_eop)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a sink-side monitor.
// Upstream sends a counting ramp; imag carries the inverted ramp.
module tb_fft_frame_sequencer;

    localparam int DW = 12;
    localparam int MX = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic [MX:0]   cfg_pts;
    logic          cfg_inverse;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          sink_valid;
    logic          sink_ready;
    logic          sink_sop;
    logic          sink_eop;
    logic [1:0]    sink_error;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic [MX:0]   fft_pts;
    logic          inverse;
    logic [1:0]    source_error;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          err;
    logic          cfg_err;

    fft_frame_sequencer #(
        .DW       (DW),
        .MAX_LOG2 (MX),
        .MIN_LOG2 (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear        (clear),
        .cfg_pts      (cfg_pts),
        .cfg_inverse  (cfg_inverse),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_error   (sink_error),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fft_pts      (fft_pts),
        .inverse      (inverse),
        .source_error (source_error),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .err          (err),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src = '0;
    logic          acc_prev = 1'b0;
    logic          rdy_mode = 1'b0;
    int            tog = 0;

    int            mon_beats = 0;
    int            mon_frames = 0;
    int            mon_sops = 0;
    int            mon_fd = 0;
    int            gap_cnt = 0;
    int            last_gap = 0;
    int            last_len = 0;
    logic          last_inv = 1'b0;
    logic [MX:0]   last_pts = '0;
    int            exp_len = 64;
    int            next_len = 64;
    logic [DW-1:0] exp_next = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_real = '0;
    logic [DW-1:0] prev_imag = '0;
    logic          prev_sop = 1'b0;
    logic          prev_eop = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive just after the rising edge, observe at the falling edge.
    task automatic cyc();
        logic          take;
        logic [DW-1:0] inv_r;
        @(posedge clk);
        #1;
        if (acc_prev) src = src + 1'b1;
        in_real = src;
        in_imag = ~src;
        if (rdy_mode) begin
            sink_ready = ((tog / 3) % 2) == 0;
            tog++;
        end else begin
            sink_ready = 1'b1;
        end
        @(negedge clk);
        take = sink_valid && sink_ready;
        if (prev_stall) begin
            check("hold_valid", 32'(sink_valid), 32'd1);
            check("hold_real", 32'(sink_real), 32'(prev_real));
            check("hold_imag", 32'(sink_imag), 32'(prev_imag));
            check("hold_sop", 32'(sink_sop), 32'(prev_sop));
            check("hold_eop", 32'(sink_eop), 32'(prev_eop));
        end
        if (take) begin
            inv_r = ~sink_real;
            check("beat_sop", 32'(sink_sop), 32'(mon_beats == 0));
            check("beat_eop", 32'(sink_eop),
                  32'(mon_beats == exp_len - 1));
            check("beat_imag", 32'(sink_imag), 32'(inv_r));
            if (!sink_sop)
                check("beat_seq", 32'(sink_real), 32'(exp_next));
            exp_next = sink_real + 1'b1;
            if (sink_sop) begin
                last_gap = gap_cnt;
                mon_sops++;
            end
            mon_beats++;
            if (sink_eop) begin
                last_len   = mon_beats;
                last_inv   = inverse;
                last_pts   = fft_pts;
                mon_frames++;
                mon_beats  = 0;
                exp_len    = next_len;
                gap_cnt    = 0;
            end
        end else if (!sink_valid) begin
            gap_cnt++;
        end
        if (frame_done) mon_fd++;
        prev_stall = sink_valid && !sink_ready;
        prev_real  = sink_real;
        prev_imag  = sink_imag;
        prev_sop   = sink_sop;
        prev_eop   = sink_eop;
        acc_prev   = in_valid && in_ready;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (mon_frames < n && k < 4000) begin
            cyc();
            k++;
        end
        check("wait_frames", 32'(mon_frames >= n), 32'd1);
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (mon_beats != n && k < 4000) begin
            cyc();
            k++;
        end
        check("wait_beats", 32'(mon_beats == n), 32'd1);
    endtask

    task automatic wait_sops(input int n);
        int k = 0;
        while (mon_sops < n && k < 4000) begin
            cyc();
            k++;
        end
        check("wait_sops", 32'(mon_sops >= n), 32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        clear        = 1'b0;
        cfg_pts      = 11'd64;
        cfg_inverse  = 1'b0;
        in_valid     = 1'b0;
        in_real      = '0;
        in_imag      = '1;
        sink_ready   = 1'b1;
        source_error = 2'b00;
        cyc();
        cyc();

        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sink_valid", 32'(sink_valid), 32'd0);
        check("rst_sop", 32'(sink_sop), 32'd0);
        check("rst_eop", 32'(sink_eop), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_inverse", 32'(inverse), 32'd0);
        check("rst_sink_error", 32'(sink_error), 32'd0);
        check("rst_real", 32'(sink_real), 32'd0);
        check("rst_imag", 32'(sink_imag), 32'd0);
        check("rst_fft_pts", 32'(fft_pts), 32'd1024);
        check("rst_frame_count", 32'(frame_count), 32'd0);

        reset_n = 1'b1;
        cyc();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Frame 1: continuous flow, 64 points.
        in_valid = 1'b1;
        enable   = 1'b1;
        wait_frames(1);
        cyc();
        check("f1_len", 32'(last_len), 32'd64);
        check("f1_pts", 32'(last_pts), 32'd64);
        check("f1_count", 32'(frame_count), 32'd1);
        check("f1_done_pulses", 32'(mon_fd), 32'd1);
        wait_sops(2);
        check("f1_gap", 32'(last_gap >= 1 && last_gap <= 2), 32'd1);

        // Frames 2-3: sink_ready toggles every 3 cycles.
        rdy_mode = 1'b1;
        wait_frames(2);
        check("f2_len", 32'(last_len), 32'd64);
        wait_frames(3);
        check("f3_len", 32'(last_len), 32'd64);
        rdy_mode = 1'b0;
        cyc();
        check("f3_count", 32'(frame_count), 32'd3);

        // Config change mid-frame applies to the next frame only.
        wait_beats(10);
        cfg_pts     = 11'd256;
        cfg_inverse = 1'b1;
        next_len    = 256;
        wait_frames(4);
        check("f4_len", 32'(last_len), 32'd64);
        check("f4_pts", 32'(last_pts), 32'd64);
        check("f4_inv", 32'(last_inv), 32'd0);
        wait_frames(5);
        check("f5_len", 32'(last_len), 32'd256);
        check("f5_pts", 32'(last_pts), 32'd256);
        check("f5_inv", 32'(last_inv), 32'd1);

        // Enable dropped mid-frame: frame completes, then idle.
        wait_beats(20);
        enable = 1'b0;
        wait_frames(6);
        check("f6_len", 32'(last_len), 32'd256);
        repeat (10) cyc();
        check("f6_count", 32'(frame_count), 32'd6);
        check("f6_idle_ready", 32'(in_ready), 32'd0);
        check("f6_idle_valid", 32'(sink_valid), 32'd0);
        check("f6_done_pulses", 32'(mon_fd), 32'd6);
        check("f6_pts_kept", 32'(fft_pts), 32'd256);
        check("f6_inv_kept", 32'(inverse), 32'd1);

        // Invalid length parks in ERROR with cfg_err.
        cfg_pts = 11'd100;
        enable  = 1'b1;
        repeat (3) cyc();
        check("cfg_err_err", 32'(err), 32'd1);
        check("cfg_err_flag", 32'(cfg_err), 32'd1);
        check("cfg_err_ready", 32'(in_ready), 32'd0);
        enable = 1'b0;
        clear  = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_cfg_err", 32'(cfg_err), 32'd0);
        cyc();
        check("clr_idle_ready", 32'(in_ready), 32'd0);
        check("clr_idle_err", 32'(err), 32'd0);

        // Core error at beat 30 discards the partial frame.
        cfg_pts     = 11'd64;
        cfg_inverse = 1'b0;
        exp_len     = 64;
        next_len    = 64;
        enable      = 1'b1;
        wait_beats(30);
        source_error = 2'b01;
        cyc();
        source_error = 2'b00;
        mon_beats    = 0;
        check("serr_err", 32'(err), 32'd1);
        check("serr_valid", 32'(sink_valid), 32'd0);
        check("serr_ready", 32'(in_ready), 32'd0);
        check("serr_cfg_err", 32'(cfg_err), 32'd0);
        check("serr_count", 32'(frame_count), 32'd6);
        cyc();
        check("serr_parked", 32'(err), 32'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("serr_clear", 32'(err), 32'd0);
        wait_frames(7);
        cyc();
        check("f7_len", 32'(last_len), 32'd64);
        check("f7_inv", 32'(last_inv), 32'd0);
        check("f7_count", 32'(frame_count), 32'd7);
        enable = 1'b0;
        repeat (4) cyc();
        check("end_done_pulses", 32'(mon_fd), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
